// File: rtl/conv2d_stream_engine_pkg.sv
// Shared types and width helpers for the streaming 2-D convolution engine.
// Derived widths are functions so every instance computes them the same way.
package conv2d_stream_engine_pkg;

  localparam int DefImgW = 28;
  localparam int DefImgH = 28;
  localparam int DefK    = 3;
  localparam int DefDw   = 8;
  localparam int DefWw   = 8;
  localparam int DefOw   = 16;

  typedef struct packed {
    logic valid;
    logic last;
  } stageCtl_t;

  function automatic int ctrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int prodWidth(
    input int dw,
    input int ww
  );
    return dw + ww + 1;
  endfunction

  function automatic int accWidth(
    input int dw,
    input int ww,
    input int k
  );
    return prodWidth(dw, ww) + $clog2(k * k);
  endfunction

  function automatic int maxInt(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv2d_stream_engine_line_buffer.sv
// One image row of delay: the oldest of DEPTH accepted pixels is on dout.
// Shifts only when en is high so stalls and idle cycles keep alignment.
module conv2d_stream_engine_line_buffer #(
  parameter int DEPTH = 28,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming KxK valid-position convolution with valid/ready backpressure,
// optional ReLU and saturated signed output.
module conv2d_stream_engine
  import conv2d_stream_engine_pkg::*;
#(
  parameter int IMG_W = DefImgW,
  parameter int IMG_H = DefImgH,
  parameter int K     = DefK,
  parameter int DW    = DefDw,
  parameter int WW    = DefWw,
  parameter int OW    = DefOw
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic                     w_we,
  input  logic [$clog2(K*K)-1:0]   w_addr,
  input  logic signed [WW-1:0]     w_data,
  input  logic                     relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OW-1:0]     out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int NTAP  = K * K;
  localparam int PW    = prodWidth(DW, WW);
  localparam int ACC_W = accWidth(DW, WW, K);
  localparam int CW    = ctrWidth(IMG_W);
  localparam int RW    = ctrWidth(IMG_H);
  localparam int XW    = maxInt(ACC_W, OW);

  localparam logic signed [XW-1:0] SatHi =
    {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] SatLo =
    {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic stall;
  logic accept;
  logic consume;

  logic              outValid;
  logic signed [OW-1:0] outData;
  logic              outLast;

  assign stall    = outValid & ~out_ready;
  assign accept   = in_valid & ~stall;
  assign consume  = outValid & out_ready;
  assign in_ready = ~stall;

  // Raster position of the pixel currently offered

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          colEnd;
  logic          rowEnd;
  logic          winHit;
  logic          frameEnd;
  logic          frameStart;

  assign colEnd     = (col == CW'(IMG_W-1));
  assign rowEnd     = (row == RW'(IMG_H-1));
  assign winHit     = (row >= RW'(K-1)) && (col >= CW'(K-1));
  assign frameEnd   = rowEnd & colEnd;
  assign frameStart = (row == '0) && (col == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (colEnd) begin
        col <= '0;
        row <= rowEnd ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Frames in flight: a new frame may start while the old tail drains.

  logic [1:0] frames;
  logic       lastDone;
  logic       startNow;

  assign lastDone = consume & outLast;
  assign startNow = accept & frameStart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames <= '0;
    end else begin
      frames <= frames + 2'(startNow) - 2'(lastDone);
    end
  end

  assign busy = |frames;

  logic signed [WW-1:0] wReg [NTAP];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) begin
        wReg[i] <= '0;
      end
    end else if (w_we && !busy && int'(w_addr) < NTAP) begin
      wReg[w_addr] <= w_data;
    end
  end

  // colIn[K-1] is the live row, colIn[0] the oldest buffered row

  logic [DW-1:0] lbOut [K-1];
  logic [DW-1:0] colIn [K];

  always_comb begin
    colIn[K-1] = in_data;
    for (int k = 0; k < K-1; k++) begin
      colIn[k] = lbOut[K-2-k];
    end
  end

  for (genvar g = 0; g < K-1; g++) begin : gLb
    conv2d_stream_engine_line_buffer #(
      .DEPTH(IMG_W),
      .DW   (DW)
    ) uLb (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .din (colIn[K-1-g]),
      .dout(lbOut[g])
    );
  end

  // S1: window capture

  logic [DW-1:0] win [K][K];
  stageCtl_t     s1Ctl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= colIn[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Ctl <= '0;
    end else if (!stall) begin
      s1Ctl.valid <= accept & winHit;
      s1Ctl.last  <= accept & frameEnd;
    end
  end

  // S2: parallel multiplies

  function automatic logic signed [PW-1:0] mulTap(
    input logic [DW-1:0]        p,
    input logic signed [WW-1:0] w
  );
    logic signed [PW-1:0] pe;
    logic signed [PW-1:0] we;
    pe = PW'(signed'({1'b0, p}));
    we = PW'(w);
    return pe * we;
  endfunction

  logic signed [PW-1:0] prod [NTAP];
  stageCtl_t            s2Ctl;
  logic                 s2Relu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Ctl  <= '0;
      s2Relu <= 1'b0;
      for (int i = 0; i < NTAP; i++) begin
        prod[i] <= '0;
      end
    end else if (!stall) begin
      s2Ctl  <= s1Ctl;
      s2Relu <= relu_en;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          prod[r*K+c] <= mulTap(win[r][c], wReg[r*K+c]);
        end
      end
    end
  end

  // S3: exact sum

  logic signed [ACC_W-1:0] sumComb;
  logic signed [ACC_W-1:0] s3Sum;
  stageCtl_t               s3Ctl;
  logic                    s3Relu;

  always_comb begin
    sumComb = '0;
    for (int i = 0; i < NTAP; i++) begin
      sumComb = sumComb + ACC_W'(prod[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3Sum  <= '0;
      s3Ctl  <= '0;
      s3Relu <= 1'b0;
    end else if (!stall) begin
      s3Sum  <= sumComb;
      s3Ctl  <= s2Ctl;
      s3Relu <= s2Relu;
    end
  end

  // S4: ReLU before clamp, then the output register

  logic signed [XW-1:0] sx;
  logic signed [OW-1:0] satVal;

  always_comb begin
    sx = XW'(s3Sum);
    if (s3Relu && sx < 0) begin
      sx = '0;
    end
    if (sx > SatHi) begin
      satVal = OW'(SatHi);
    end else if (sx < SatLo) begin
      satVal = OW'(SatLo);
    end else begin
      satVal = OW'(sx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid <= 1'b0;
      outData  <= '0;
      outLast  <= 1'b0;
    end else if (!stall) begin
      outValid <= s3Ctl.valid;
      outLast  <= s3Ctl.valid & s3Ctl.last;
      if (s3Ctl.valid) begin
        outData <= satVal;
      end
    end
  end

  assign out_valid = outValid;
  assign out_data  = outData;
  assign out_last  = outLast;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Randomised bench for conv2d_stream_engine on a 5x5 image, 3x3 kernel.
// Expected results come from a direct convolution over the frame array.
module tb_conv2d_stream_engine;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int K  = 3;
  localparam int NT = K * K;
  localparam int NP = W * H;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              w_we;
  logic [3:0]        w_addr;
  logic signed [7:0] w_data;
  logic              relu_en;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] out_data;
  logic              out_last;
  logic              busy;

  always #5 clk = ~clk;

  conv2d_stream_engine #(
    .IMG_W(W), .IMG_H(H), .K(K),
    .DW(8), .WW(8), .OW(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .relu_en  (relu_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  int vecCnt = 0;
  int errCnt = 0;
  int cyc = 0;

  int expData[$];
  int expLast[$];
  int gotData[$];
  int gotLast[$];

  int pixArr[NP];
  int wts[NT];
  int accCyc[NP];
  bit reluCfg = 0;

  int holdLow = 0;
  bit randRdy = 0;
  bit armHold = 0;
  int stallCnt = 0;
  int firstOutCyc = -1;

  bit   prevStall = 0;
  int   prevData = 0;
  int   prevLast = 0;

  task automatic checkVal(input string tag, input int obs, input int exp);
    vecCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (holdLow > 0) begin
        out_ready = 1'b0;
        holdLow--;
      end else if (randRdy) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Output monitor: handshake rule, hold-under-stall, result capture
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 0;
      end else begin
        checkVal("inReady", int'(in_ready),
                 int'(!(out_valid && !out_ready)));
        if (prevStall) begin
          checkVal("holdValid", int'(out_valid), 1);
          checkVal("holdData", int'(out_data), prevData);
          checkVal("holdLast", int'(out_last), prevLast);
        end
        if (out_valid && !out_ready) stallCnt++;
        if (out_valid && firstOutCyc < 0) firstOutCyc = cyc;
        if (armHold && out_valid) begin
          holdLow = 10;
          armHold = 0;
        end
        if (out_valid && out_ready) begin
          gotData.push_back(int'(out_data));
          gotLast.push_back(int'(out_last));
        end
        prevStall = out_valid && !out_ready;
        prevData  = int'(out_data);
        prevLast  = int'(out_last);
      end
    end
  end

  task automatic modelFrame();
    for (int r = K-1; r < H; r++) begin
      for (int c = K-1; c < W; c++) begin
        int s;
        s = 0;
        for (int kr = 0; kr < K; kr++) begin
          for (int kc = 0; kc < K; kc++) begin
            s += pixArr[(r-K+1+kr)*W + (c-K+1+kc)] * wts[kr*K+kc];
          end
        end
        if (reluCfg && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        expData.push_back(s);
        expLast.push_back((r == H-1 && c == W-1) ? 1 : 0);
      end
    end
  endtask

  task automatic sendFrame(input int nPix, input bit gaps, input int wrAt);
    for (int i = 0; i < nPix; i++) begin
      int t;
      t = 0;
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = 8'(pixArr[i]);
      if (i == wrAt) begin
        w_we   = 1'b1;
        w_addr = 4'd4;
        w_data = 8'sd5;
      end
      @(negedge clk);
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) checkVal("acceptTimeout", 0, 1);
      accCyc[i] = cyc + 1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      w_we     = 1'b0;
    end
  endtask

  task automatic loadW();
    int t;
    t = 0;
    while (busy && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkVal("loadIdle", int'(busy), 0);
    for (int k = 0; k < NT; k++) begin
      w_we   = 1'b1;
      w_addr = 4'(k);
      w_data = 8'(wts[k]);
      @(posedge clk);
      #1;
    end
    w_we = 1'b0;
  endtask

  task automatic drain();
    int t;
    int n;
    t = 0;
    while (gotData.size() < expData.size() && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    checkVal("resultCount", gotData.size(), expData.size());
    n = (gotData.size() < expData.size()) ? gotData.size() : expData.size();
    for (int i = 0; i < n; i++) begin
      checkVal("result", gotData[i], expData[i]);
      checkVal("last", gotLast[i], expLast[i]);
    end
    checkVal("busyDone", int'(busy), 0);
    gotData.delete();
    gotLast.delete();
    expData.delete();
    expLast.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState();
    checkVal("rstOutValid", int'(out_valid), 0);
    checkVal("rstInReady", int'(in_ready), 1);
    checkVal("rstOutData", int'(out_data), 0);
    checkVal("rstOutLast", int'(out_last), 0);
    checkVal("rstBusy", int'(busy), 0);
  endtask

  task automatic fillConst(input int p, input int w);
    for (int i = 0; i < NP; i++) pixArr[i] = p;
    for (int k = 0; k < NT; k++) wts[k] = w;
  endtask

  task automatic fillRand();
    for (int i = 0; i < NP; i++) pixArr[i] = $urandom_range(0, 255);
    for (int k = 0; k < NT; k++) wts[k] = $urandom_range(0, 255) - 128;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    w_we     = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    relu_en  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // all ones, with an ignored write while the frame is busy
    fillConst(1, 1);
    loadW();
    modelFrame();
    sendFrame(NP, 0, 10);
    drain();

    // the same write while idle takes effect
    wts[4] = 5;
    loadW();
    modelFrame();
    sendFrame(NP, 0, -1);
    drain();

    // centre tap passes the pixel above-left of the window corner
    for (int k = 0; k < NT; k++) wts[k] = 0;
    wts[4] = 1;
    for (int i = 0; i < NP; i++) pixArr[i] = i;
    loadW();
    firstOutCyc = -1;
    modelFrame();
    sendFrame(NP, 0, -1);
    checkVal("latency", firstOutCyc - accCyc[12], 3);
    drain();

    // positive and negative saturation, then ReLU
    fillConst(255, 127);
    loadW();
    modelFrame();
    sendFrame(NP, 0, -1);
    drain();
    fillConst(255, -128);
    loadW();
    modelFrame();
    sendFrame(NP, 0, -1);
    drain();
    reluCfg = 1;
    relu_en = 1'b1;
    modelFrame();
    sendFrame(NP, 0, -1);
    drain();
    reluCfg = 0;
    relu_en = 1'b0;

    // ten-cycle downstream stall once results start flowing
    fillRand();
    loadW();
    stallCnt = 0;
    armHold = 1;
    modelFrame();
    sendFrame(NP, 0, -1);
    drain();
    checkVal("stallCycles", stallCnt, 10);

    // random frames with input gaps and random backpressure
    randRdy = 1;
    for (int f = 0; f < 4; f++) begin
      fillRand();
      reluCfg = $urandom_range(0, 1);
      relu_en = reluCfg;
      loadW();
      modelFrame();
      sendFrame(NP, 1, -1);
      drain();
    end
    fillRand();
    loadW();
    modelFrame();
    sendFrame(NP, 1, -1);
    for (int i = 0; i < NP; i++) pixArr[i] = $urandom_range(0, 255);
    modelFrame();
    sendFrame(NP, 1, -1);
    drain();
    randRdy = 0;
    reluCfg = 0;
    relu_en = 1'b0;

    // reset mid-frame clears state and weights
    fillConst(1, 1);
    loadW();
    sendFrame(12, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    rst = 1'b0;
    gotData.delete();
    gotLast.delete();
    expData.delete();
    expLast.delete();
    for (int k = 0; k < NT; k++) wts[k] = 0;
    modelFrame();
    sendFrame(NP, 0, -1);
    drain();
    fillConst(1, 1);
    loadW();
    modelFrame();
    sendFrame(NP, 0, -1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
